// File: rtl/controle_jogo_memoria_pkg.sv
// Shared definitions for the memory-game control unit: state encoding,
// output bundle and the Moore output decode.
package controle_jogo_memoria_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    MOSTRA         = 4'h3,
    PROX_MOSTRA    = 4'h4,
    ZERA_JOGADA    = 4'h5,
    ESPERA_JOGADA  = 4'h6,
    REGISTRA       = 4'h7,
    COMPARACAO     = 4'h8,
    PROXIMA_JOGADA = 4'h9,
    PROXIMA_RODADA = 4'hA,
    FIM_ACERTOU    = 4'hB,
    FIM_ERROU      = 4'hC,
    FIM_TIMEOUT    = 4'hD
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_r;
    logic conta_r;
    logic registra_r;
    logic zera_m;
    logic conta_m;
    logic zera_t;
    logic conta_t;
    logic mostra_leds;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  // Outputs asserted in each state; everything else stays low.
  function automatic saidas_t decodifica_saidas(input estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      PREPARACAO: begin
        s.zera_e = 1'b1;
        s.zera_r = 1'b1;
        s.zera_m = 1'b1;
        s.zera_t = 1'b1;
      end
      INICIO_RODADA: begin
        s.zera_e = 1'b1;
        s.zera_m = 1'b1;
      end
      MOSTRA: begin
        s.mostra_leds = 1'b1;
        s.conta_m     = 1'b1;
      end
      PROX_MOSTRA: begin
        s.conta_e = 1'b1;
        s.zera_m  = 1'b1;
      end
      ZERA_JOGADA: begin
        s.zera_e = 1'b1;
        s.zera_t = 1'b1;
      end
      ESPERA_JOGADA:  s.conta_t    = 1'b1;
      REGISTRA:       s.registra_r = 1'b1;
      PROXIMA_JOGADA: begin
        s.conta_e = 1'b1;
        s.zera_t  = 1'b1;
      end
      PROXIMA_RODADA: s.conta_r = 1'b1;
      FIM_ACERTOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto     = 1'b1;
        s.perdeu     = 1'b1;
        s.db_timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/controle_jogo_memoria.sv
// Moore control FSM for the memory-sequence game datapath. Outputs are
// decoded from the next state and registered so they track the state register.
module controle_jogo_memoria
  import controle_jogo_memoria_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada,
  input  logic                igual,
  input  logic                enderecoIgualRodada,
  input  logic                fimR,
  input  logic                fimM,
  input  logic                timeout,
  output logic                zeraE,
  output logic                contaE,
  output logic                zeraR,
  output logic                contaR,
  output logic                registraR,
  output logic                zeraM,
  output logic                contaM,
  output logic                zeraT,
  output logic                contaT,
  output logic                mostra_leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  estado_t estado_q, estado_d;
  saidas_t saidas_q, saidas_d;

  // State and output registers; reset clears both at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= saidas_d;
    end
  end

  // Next-state logic; unused encodings fall back to inicial.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     estado_d = INICIO_RODADA;
      INICIO_RODADA:  estado_d = MOSTRA;
      MOSTRA: begin
        if (!fimM) begin
          estado_d = MOSTRA;
        end else if (enderecoIgualRodada) begin
          estado_d = ZERA_JOGADA;
        end else begin
          estado_d = PROX_MOSTRA;
        end
      end
      PROX_MOSTRA:    estado_d = MOSTRA;
      ZERA_JOGADA:    estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada) begin
          estado_d = REGISTRA;
        end else if (timeout) begin
          estado_d = FIM_TIMEOUT;
        end else begin
          estado_d = ESPERA_JOGADA;
        end
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual) begin
          estado_d = FIM_ERROU;
        end else if (!enderecoIgualRodada) begin
          estado_d = PROXIMA_JOGADA;
        end else if (fimR) begin
          estado_d = FIM_ACERTOU;
        end else begin
          estado_d = PROXIMA_RODADA;
        end
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) begin
          estado_d = PREPARACAO;
        end else begin
          estado_d = estado_q;
        end
      end
      default:        estado_d = INICIAL;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    saidas_d = decodifica_saidas(estado_d);
  end

  assign zeraE       = saidas_q.zera_e;
  assign contaE      = saidas_q.conta_e;
  assign zeraR       = saidas_q.zera_r;
  assign contaR      = saidas_q.conta_r;
  assign registraR   = saidas_q.registra_r;
  assign zeraM       = saidas_q.zera_m;
  assign contaM      = saidas_q.conta_m;
  assign zeraT       = saidas_q.zera_t;
  assign contaT      = saidas_q.conta_t;
  assign mostra_leds = saidas_q.mostra_leds;
  assign pronto      = saidas_q.pronto;
  assign ganhou      = saidas_q.ganhou;
  assign perdeu      = saidas_q.perdeu;
  assign db_timeout  = saidas_q.db_timeout;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_controle_jogo_memoria.sv
// Table-driven bench for controle_jogo_memoria with a scoreboard queue of
// expected state/output pairs.
module tb_controle_jogo_memoria;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, enderecoIgualRodada = 1'b0;
  logic fimR = 1'b0, fimM = 1'b0, timeout = 1'b0;
  logic zeraE, contaE, zeraR, contaR, registraR, zeraM, contaM, zeraT, contaT;
  logic mostra_leds, pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  controle_jogo_memoria dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada), .fimR(fimR), .fimM(fimM), .timeout(timeout),
    .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR), .registraR(registraR),
    .zeraM(zeraM), .contaM(contaM), .zeraT(zeraT), .contaT(contaT),
    .mostra_leds(mostra_leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Input bit positions: {iniciar, jogada, igual, eir, fimR, fimM, timeout}
  localparam logic [6:0] N   = 7'b0000000;
  localparam logic [6:0] INI = 7'b1000000;
  localparam logic [6:0] JOG = 7'b0100000;
  localparam logic [6:0] IGU = 7'b0010000;
  localparam logic [6:0] EIR = 7'b0001000;
  localparam logic [6:0] FR  = 7'b0000100;
  localparam logic [6:0] FM  = 7'b0000010;
  localparam logic [6:0] TO  = 7'b0000001;

  typedef struct { logic [6:0] ent; logic [3:0] est; } vec_t;
  typedef struct { logic [3:0] est; logic [13:0] sai; string nome; } esp_t;

  vec_t tab[$];
  esp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs, bits {zeraE,contaE,zeraR,contaR,registraR,zeraM,contaM,
  // zeraT,contaT,mostra_leds,pronto,ganhou,perdeu,db_timeout}.
  function automatic logic [13:0] esperado(input logic [3:0] e);
    logic [13:0] v;
    v = 14'd0;
    case (e)
      4'h1: begin v[13] = 1'b1; v[11] = 1'b1; v[8] = 1'b1; v[6] = 1'b1; end
      4'h2: begin v[13] = 1'b1; v[8] = 1'b1; end
      4'h3: begin v[4] = 1'b1; v[7] = 1'b1; end
      4'h4: begin v[12] = 1'b1; v[8] = 1'b1; end
      4'h5: begin v[13] = 1'b1; v[6] = 1'b1; end
      4'h6: v[5] = 1'b1;
      4'h7: v[9] = 1'b1;
      4'h9: begin v[12] = 1'b1; v[6] = 1'b1; end
      4'hA: v[10] = 1'b1;
      4'hB: begin v[3] = 1'b1; v[2] = 1'b1; end
      4'hC: begin v[3] = 1'b1; v[1] = 1'b1; end
      4'hD: begin v[3] = 1'b1; v[1] = 1'b1; v[0] = 1'b1; end
      default: v = 14'd0;
    endcase
    return v;
  endfunction

  function automatic logic [13:0] saidas_dut();
    return {zeraE, contaE, zeraR, contaR, registraR, zeraM, contaM, zeraT, contaT,
            mostra_leds, pronto, ganhou, perdeu, db_timeout};
  endfunction

  task automatic compara(input string nome, input logic [3:0] est, input logic [13:0] sai);
    n_cmp++;
    if (db_estado !== est || saidas_dut() !== sai) begin
      n_err++;
      $display("FAIL %s: got estado=%h saidas=%b, expected estado=%h saidas=%b",
               nome, db_estado, saidas_dut(), est, sai);
    end
  endtask

  task automatic aplica(input logic [6:0] ent, input logic [3:0] est, input string nome);
    esp_t e;
    @(negedge clock);
    {iniciar, jogada, igual, enderecoIgualRodada, fimR, fimM, timeout} = ent;
    sb.push_back('{est, esperado(est), nome});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    compara(e.nome, e.est, e.sai);
  endtask

  task automatic add(input logic [6:0] ent, input logic [3:0] est);
    tab.push_back('{ent, est});
  endtask

  task automatic roda_tabela(input string nome);
    for (int i = 0; i < tab.size(); i++) begin
      aplica(tab[i].ent, tab[i].est, $sformatf("%s[%0d]", nome, i));
    end
    tab.delete();
  endtask

  initial begin
    // Reset held with iniciar high: must stay in inicial with outputs low.
    iniciar = 1'b1;
    repeat (2) @(posedge clock);
    #1 compara("reset_hold", 4'h0, 14'd0);
    @(negedge clock);
    reset = 1'b1;
    iniciar = 1'b0;

    add(INI, 4'h1); add(N, 4'h2); add(N, 4'h3); add(N, 4'h3);
    roda_tabela("start");

    // Asynchronous reset mid-mostra.
    @(negedge clock);
    #2 reset = 1'b0;
    #1 compara("reset_async", 4'h0, 14'd0);
    @(negedge clock);
    reset = 1'b1;

    // Round 1 win, round 2 display and timeout on second move.
    add(INI, 4'h1); add(N, 4'h2); add(N, 4'h3); add(FM|EIR, 4'h5); add(JOG, 4'h6);
    add(INI|JOG, 4'h7); add(JOG, 4'h8); add(IGU|EIR, 4'hA); add(INI, 4'h2);
    add(N, 4'h3); add(FM, 4'h4); add(N, 4'h3); add(N, 4'h3); add(FM|EIR, 4'h5);
    add(N, 4'h6); add(N, 4'h6); add(JOG, 4'h7); add(N, 4'h8); add(IGU, 4'h9);
    add(JOG, 4'h6); add(TO, 4'hD);
    roda_tabela("rodada");

    // End state holds for 100 cycles regardless of other inputs.
    for (int i = 0; i < 100; i++) begin
      aplica({1'b0, 6'($urandom_range(0, 63))}, 4'hD, "hold_timeout");
    end

    // Wrong move, jogada-over-timeout priority, last-round win, restart.
    add(INI, 4'h1); add(N, 4'h2); add(N, 4'h3); add(FM|EIR, 4'h5); add(N, 4'h6);
    add(JOG|TO, 4'h7); add(N, 4'h8); add(EIR|FR, 4'hC); add(N, 4'hC);
    add(INI, 4'h1); add(N, 4'h2); add(N, 4'h3); add(FM|EIR, 4'h5); add(N, 4'h6);
    add(JOG, 4'h7); add(N, 4'h8); add(IGU|EIR|FR, 4'hB); add(JOG|TO, 4'hB);
    add(INI, 4'h1); add(INI, 4'h2);
    roda_tabela("fim");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
